// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - 8N1 UART receiver with 2-of-3 mid-bit voting and a running byte count
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 32,
  parameter int DATA_BITS    = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int PCOUNT_W     = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy,
  output logic [PCOUNT_W-1:0]  pixel_count
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int H     = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] SAMP_A   = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] SAMP_B   = CNT_W'(H);
  localparam logic [CNT_W-1:0] SAMP_C   = CNT_W'(H + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_W-1:0]       bit_idx_q, bit_idx_d;
  logic [1:0]             samp_q, samp_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_out_q, data_out_d;
  logic                   data_valid_q, data_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic [PCOUNT_W-1:0]    pixel_count_q, pixel_count_d;

  logic rxs;
  logic cnt_wrap;
  logic decide;
  logic maj;

  assign rxs      = sync_q[SYNC_STAGES-1];
  assign cnt_wrap = (cnt_q == CNT_MAX);
  assign decide   = (cnt_q == SAMP_C);
  // Third vote is the live synchronized sample taken on the deciding edge.
  assign maj      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);

  always_comb begin
    state_d       = state_q;
    sync_d        = {sync_q[SYNC_STAGES-2:0], rx};
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    samp_d        = samp_q;
    shift_d       = shift_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    frame_err_d   = 1'b0;
    pixel_count_d = pixel_count_q;

    if (state_q != S_IDLE) begin
      cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
      if (cnt_q == SAMP_A) samp_d[0] = rxs;
      if (cnt_q == SAMP_B) samp_d[1] = rxs;
    end

    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (decide && maj) begin
          state_d = S_IDLE;
        end else if (cnt_wrap) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (decide) shift_d = {maj, shift_q[DATA_BITS-1:1]};
        if (cnt_wrap) begin
          if (bit_idx_q == LAST_BIT) state_d = S_STOP;
          else bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      S_STOP: begin
        // Leave on the vote so a start bit right behind the stop bit is caught.
        if (decide) begin
          if (maj) begin
            data_out_d    = shift_q;
            data_valid_d  = 1'b1;
            pixel_count_d = pixel_count_q + 1'b1;
            state_d       = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      sync_q        <= '1;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      samp_q        <= '0;
      shift_q       <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      pixel_count_q <= '0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      samp_q        <= samp_d;
      shift_q       <= shift_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      frame_err_q   <= frame_err_d;
      pixel_count_q <= pixel_count_d;
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign frame_err   = frame_err_q;
  assign busy        = (state_q != S_IDLE);
  assign pixel_count = pixel_count_q;

endmodule
